// File: rtl/zrl_counter_pkg.sv
// Shared constants and FSM encoding for the zero-run-length counter.
package zrl_counter_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int NUM_WORDS  = 16;
  localparam int ZRL_WIDTH  = 4;
  localparam int RUN_WIDTH  = ZRL_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } zrl_state_e;

endpackage

// File: rtl/zrl_lane.sv
// One transformer lane: tracks the current and longest run of zero words in a
// cacheline and presents the longest run saturated to ZRL_WIDTH bits.
module zrl_lane
  import zrl_counter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 clr_i,
  input  logic                 beat_i,
  input  logic [DATA_W-1:0]    word_i,
  output logic [ZRL_WIDTH-1:0] zrl_o
);

  localparam logic [RUN_WIDTH-1:0] RUN_SAT = RUN_WIDTH'((1 << ZRL_WIDTH) - 1);

  logic [RUN_WIDTH-1:0] cur_q, cur_d;
  logic [RUN_WIDTH-1:0] max_q, max_d;
  logic [ZRL_WIDTH-1:0] zrl_q;

  function automatic logic [ZRL_WIDTH-1:0] sat_run(input logic [RUN_WIDTH-1:0] v);
    if (v > RUN_SAT) return '1;
    return v[ZRL_WIDTH-1:0];
  endfunction

  always_comb begin
    cur_d = cur_q;
    max_d = max_q;
    if (beat_i) begin
      if (word_i == '0) begin
        cur_d = cur_q + RUN_WIDTH'(1);
        if (cur_d > max_q) max_d = cur_d;
      end else begin
        cur_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cur_q <= '0;
      max_q <= '0;
      zrl_q <= '0;
    end else begin
      cur_q <= cur_d;
      max_q <= max_d;
      zrl_q <= sat_run(max_d);
    end
  end

  assign zrl_o = zrl_q;

endmodule

// File: rtl/zrl_counter.sv
// Accumulates one cacheline of beats and reports all-zero / all-same flags plus
// per-transformer maximum zero runs. Optional abort input under ZRL_ABORT_EN.
module zrl_counter #(
  parameter int NUM_FIRST_TRANSFORMER = 2,
  parameter int NUM_LAST_TRANSFORMER  = 6,
  parameter int WORD_WIDTH            = zrl_counter_pkg::WORD_WIDTH,
  parameter int NUM_WORDS             = zrl_counter_pkg::NUM_WORDS,
  localparam int NT = NUM_LAST_TRANSFORMER - NUM_FIRST_TRANSFORMER + 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic [WORD_WIDTH-1:0]                 raw_word_i,
  input  logic [WORD_WIDTH*NT-1:0]              word_i,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic                                  isAllZero_o,
  output logic                                  isAllWordSame_o,
  output logic [zrl_counter_pkg::ZRL_WIDTH*NT-1:0] zeroRunLen_o
`ifdef ZRL_ABORT_EN
  ,
  input  logic                                  abort_i
`endif
);

  import zrl_counter_pkg::*;

  localparam int CNT_W = $clog2(NUM_WORDS) + 1;

  zrl_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  all_zero_q, all_zero_d;
  logic                  same_q, same_d;
  logic [WORD_WIDTH-1:0] word0_q, word0_d;
  logic                  beat, last, clr_w, lane_clr;

  assign ready_o  = rst_n && (state_q != DONE);
  assign beat     = valid_i && ready_o;
  assign last     = (cnt_q == CNT_W'(NUM_WORDS - 1));

`ifdef ZRL_ABORT_EN
  assign clr_w = ((state_q == DONE) && ready_i) || abort_i;
`else
  assign clr_w = (state_q == DONE) && ready_i;
`endif
  assign lane_clr = !rst_n || clr_w;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    all_zero_d = all_zero_q;
    same_d     = same_q;
    word0_d    = word0_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = last ? DONE : ACCUM;
          valid_d = last;
          // The first beat of a line seeds the flags and the reference word.
          if (state_q == IDLE) begin
            all_zero_d = (raw_word_i == '0);
            same_d     = 1'b1;
            word0_d    = raw_word_i;
          end else begin
            all_zero_d = all_zero_q && (raw_word_i == '0);
            same_d     = same_q && (raw_word_i == word0_q);
          end
        end
      end
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_w) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      all_zero_q <= 1'b0;
      same_q     <= 1'b0;
      word0_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      all_zero_q <= all_zero_d;
      same_q     <= same_d;
      word0_q    <= word0_d;
    end
  end

  assign valid_o         = valid_q;
  assign isAllZero_o     = all_zero_q;
  assign isAllWordSame_o = same_q;

  // Lane k serves transformer NUM_FIRST_TRANSFORMER+k, packed from the MSBs down.
  for (genvar k = 0; k < NT; k++) begin : g_lane
    zrl_lane #(.DATA_W(WORD_WIDTH)) u_lane (
      .clk    (clk),
      .clr_i  (lane_clr),
      .beat_i (beat),
      .word_i (word_i[WORD_WIDTH*(NT-k)-1 -: WORD_WIDTH]),
      .zrl_o  (zeroRunLen_o[ZRL_WIDTH*(NT-k)-1 -: ZRL_WIDTH])
    );
  end

endmodule

// File: doc/zrl_counter.md
ZRL_COUNTER -- requirements
Module: zrl_counter

Interface
REQ-001 SHALL have parameter NUM_FIRST_TRANSFORMER, default 2, meaning the lowest transformer index served.
REQ-002 SHALL have parameter NUM_LAST_TRANSFORMER, default 6, meaning the highest transformer index served; NT = NUM_LAST_TRANSFORMER-NUM_FIRST_TRANSFORMER+1.
REQ-003 SHALL have parameter WORD_WIDTH, default 32, meaning the bits per word.
REQ-004 SHALL have parameter NUM_WORDS, default 16, meaning the words per cacheline.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-007 SHALL have port valid_i, input, 1 bit: the input beat is valid.
REQ-008 SHALL have port ready_o, output, 1 bit: the block accepts a beat.
REQ-009 SHALL have port raw_word_i, input, WORD_WIDTH bits: the untransformed cacheline word for this beat.
REQ-010 SHALL have port word_i, input, WORD_WIDTH*NT bits: the same-position word of each transformer output, with transformer NUM_FIRST_TRANSFORMER in the MSBs.
REQ-011 SHALL have port valid_o, output, 1 bit: the result is valid.
REQ-012 SHALL have port ready_i, input, 1 bit: the downstream selector consumes the result.
REQ-013 SHALL have port isAllZero_o, output, 1 bit: every raw word of the line was zero.
REQ-014 SHALL have port isAllWordSame_o, output, 1 bit: every raw word of the line equalled raw word 0.
REQ-015 SHALL have port zeroRunLen_o, output, 4*NT bits: the per-transformer maximum zero run, with transformer NUM_FIRST_TRANSFORMER in the MSBs.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCUM and DONE; ready_o SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-017 SHALL count a beat as accepted when valid_i && ready_o; a beat accepted in IDLE SHALL count as word 0 and move the FSM to ACCUM.
REQ-018 SHALL keep a word counter of $clog2(NUM_WORDS)+1 bits; acceptance of word NUM_WORDS-1 SHALL move the FSM to DONE and assert valid_o on the following cycle.
REQ-019 SHALL, per transformer lane on each accepted beat: if the word is zero, cur = cur+1 and max = max(max, cur+1); otherwise cur = 0; cur and max SHALL be 5 bits wide internally.
REQ-020 SHALL output zeroRunLen_o per lane as min(max, 15) (saturating).
REQ-021 SHALL clear isAllZero on any nonzero raw word; SHALL latch word 0 and clear isAllWordSame on any raw word differing from it; an all-zero line SHALL assert both flags.
REQ-022 SHALL drive outputs from registers; outputs SHALL be stable while valid_o=1 && ready_i=0.
REQ-023 SHALL, in DONE with ready_i=1, deassert valid_o, clear all accumulators and return to IDLE on the next edge; minimum throughput SHALL be one line per NUM_WORDS+1 cycles.
REQ-024 SHALL count no beat on a cycle with valid_i=0; accumulator state SHALL hold.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, force state=IDLE, counters=0, cur/max=0, isAllZero_o=0, isAllWordSame_o=0, zeroRunLen_o=0 and valid_o=0; ready_o SHALL be 0 while rst_n=0.
REQ-026 SHALL discard a partially accumulated line when reset is applied mid-line; the first beat after reset SHALL be word 0.

Configuration
REQ-027 SHALL, when macro ZRL_ABORT_EN is defined, add input abort_i, 1 bit; abort_i=1 SHALL clear all accumulators and force IDLE on the next edge (highest priority after reset, valid_o=0); without the macro, the port SHALL be absent and no abort path SHALL exist.

Structure
REQ-028 SHALL place WORD_WIDTH, NUM_WORDS, ZRL_WIDTH=4 and the FSM state encodings in the shared compressor package/header.
REQ-029 SHALL instantiate the sub-module zrl_lane once per transformer, holding cur/max and the saturation logic.

Verification
REQ-030 SHALL check: 16 all-zero raw and transformed words -> isAllZero_o=1, isAllWordSame_o=1, every lane=15 (saturated).
REQ-031 SHALL check: lane 2 words zero at positions 3-9, all others nonzero -> lane 2=7, other lanes=0, isAllZero_o=0.
REQ-032 SHALL check: raw words all 0xDEADBEEF -> isAllZero_o=0, isAllWordSame_o=1.
REQ-033 SHALL check: ready_i held 0 for 5 cycles after valid_o -> outputs constant and ready_o=0; ready_i=1 -> next line accepted after 1 cycle.
REQ-034 SHALL check: rst_n pulsed low after word 8 -> all outputs 0; the next 16 beats produce a correct fresh result.
REQ-035 SHALL check: valid_i toggling every other cycle with lane 4 alternating zero/nonzero -> lane 4=1, and valid_o arrives after 16 accepted beats.
